// File: rtl/cpu_controller_ws_pkg.sv
// Shared constants for the wait-state capable multicycle CPU controller.
package cpu_ctrl_pkg;

    localparam int unsigned STATE_W = 4;

    // FSM state encodings
    localparam logic [3:0] S_IF     = 4'd0;
    localparam logic [3:0] S_HALT   = 4'd1;
    localparam logic [3:0] S_ID     = 4'd2;
    localparam logic [3:0] S_BRANCH = 4'd3;
    localparam logic [3:0] S_JUMP   = 4'd4;
    localparam logic [3:0] S_C_ALU  = 4'd5;
    localparam logic [3:0] S_C_WB   = 4'd6;
    localparam logic [3:0] S_ST_EX  = 4'd7;
    localparam logic [3:0] S_ST_MEM = 4'd8;
    localparam logic [3:0] S_LD_EX  = 4'd9;
    localparam logic [3:0] S_LD_MEM = 4'd10;
    localparam logic [3:0] S_LD_WB  = 4'd11;
    localparam logic [3:0] S_IMM_EX = 4'd12;
    localparam logic [3:0] S_IMM_WB = 4'd13;
    localparam logic [3:0] S_TRAP   = 4'd14;

    // Opcodes (IR[15:12]); 11xx is the immediate group
    localparam logic [3:0] OP_LD  = 4'b0000;
    localparam logic [3:0] OP_ST  = 4'b0001;
    localparam logic [3:0] OP_JMP = 4'b0010;
    localparam logic [3:0] OP_BR  = 4'b0100;
    localparam logic [3:0] OP_C   = 4'b1000;

    // ALU operation codes
    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_NOT   = 3'b100;
    localparam logic [2:0] ALU_PASSA = 3'b101;
    localparam logic [2:0] ALU_PASSB = 3'b110;

    // Type-C func bit positions
    localparam int unsigned F_MOVETO   = 0;
    localparam int unsigned F_MOVEFROM = 1;
    localparam int unsigned F_ADD      = 2;
    localparam int unsigned F_SUB      = 3;
    localparam int unsigned F_AND      = 4;
    localparam int unsigned F_OR       = 5;
    localparam int unsigned F_NOT      = 6;
    localparam int unsigned F_NOP      = 7;

    // ALU operation source: fixed code from the FSM or decoded from func
    typedef enum logic {
        AOP_FIXED = 1'b0,
        AOP_FUNC  = 1'b1
    } aluop_e;

endpackage

// File: rtl/cpu_controller_ws_if.sv
// Controller <-> decoder/datapath/memory signal bundle.
interface cpu_controller_ws_if #(
    parameter int unsigned FUNC_W = 9,
    parameter int unsigned CNT_W  = 16
);
    logic [3:0]        opcode;
    logic [FUNC_W-1:0] func;
    logic              zero;
    logic              mem_ready;
    logic              stall_req;

    logic              mem_req;
    logic              AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, A3Src;
    logic              PCWrite, Branch, OldPCWrite, MDRWrite;
    logic [1:0]        ALUSrcA, ALUSrcB, ImmSrc, PCSrc;
    logic [2:0]        ALUControl;
    logic              halted, illegal_op, bus_err, retire;
    logic [CNT_W-1:0]  instret;

    modport master (
        input  opcode, func, zero, mem_ready, stall_req,
        output mem_req, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, A3Src,
               PCWrite, Branch, OldPCWrite, MDRWrite,
               ALUSrcA, ALUSrcB, ImmSrc, PCSrc, ALUControl,
               halted, illegal_op, bus_err, retire, instret
    );

    modport slave (
        output opcode, func, zero, mem_ready, stall_req,
        input  mem_req, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, A3Src,
               PCWrite, Branch, OldPCWrite, MDRWrite,
               ALUSrcA, ALUSrcB, ImmSrc, PCSrc, ALUControl,
               halted, illegal_op, bus_err, retire, instret
    );
endinterface

// File: rtl/cpu_controller_ws_alu_decoder.sv
// ALU control decode: fixed FSM code or Type-C one-hot func field.
module alu_decoder
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned FUNC_W = 9
) (
    input  aluop_e            aluop_i,
    input  logic [2:0]        fixed_i,
    input  logic [FUNC_W-1:0] func_i,
    output logic [2:0]        alu_ctrl_o,
    output logic              no_op_o,
    output logic              move_to_o
);
    logic       one_hot;
    logic [2:0] func_code;

    // Exactly one func bit set; zero or multi-hot falls back to nop
    always_comb one_hot = (func_i != '0) && ((func_i & (func_i - FUNC_W'(1))) == '0);

    // Map the single active func bit to an ALU code
    always_comb begin
        func_code = ALU_ADD;
        no_op_o   = 1'b1;
        move_to_o = 1'b0;
        if (one_hot) begin
            no_op_o = 1'b0;
            case (1'b1)
                func_i[F_MOVETO]:   begin func_code = ALU_PASSA; move_to_o = 1'b1; end
                func_i[F_MOVEFROM]: func_code = ALU_PASSB;
                func_i[F_ADD]:      func_code = ALU_ADD;
                func_i[F_SUB]:      func_code = ALU_SUB;
                func_i[F_AND]:      func_code = ALU_AND;
                func_i[F_OR]:       func_code = ALU_OR;
                func_i[F_NOT]:      func_code = ALU_NOT;
                default:            no_op_o   = 1'b1;
            endcase
        end
    end

    // Select between FSM-supplied and func-derived operation
    always_comb alu_ctrl_o = (aluop_i == AOP_FUNC) ? func_code : fixed_i;

endmodule

// File: rtl/cpu_controller_ws.sv
// Multicycle CPU controller with memory wait states, traps, halt and instret.
module cpu_controller_ws
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned FUNC_W      = 9,
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    cpu_controller_ws_if.master bus
);
    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1) + 1;

    logic [STATE_W-1:0] state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]   instret_q, instret_d;
    logic               illegal_q, illegal_d;
    logic               bus_err_q, bus_err_d;
    logic               timeout;
    aluop_e             aluop;
    logic [2:0]         alu_fixed;
    logic [2:0]         alu_ctrl;
    logic               no_op, move_to;

    alu_decoder #(.FUNC_W(FUNC_W)) u_alu_dec (
        .aluop_i    (aluop),
        .fixed_i    (alu_fixed),
        .func_i     (bus.func),
        .alu_ctrl_o (alu_ctrl),
        .no_op_o    (no_op),
        .move_to_o  (move_to)
    );

    // Wait budget exhausted for the current memory access
    always_comb timeout = (MEM_TIMEOUT != 0) && (wait_q == WAIT_W'(MEM_TIMEOUT));

    // Next state, wait counter and datapath controls
    always_comb begin
        state_d        = state_q;
        wait_d         = '0;
        illegal_d      = illegal_q;
        bus_err_d      = bus_err_q;
        aluop          = AOP_FIXED;
        alu_fixed      = ALU_ADD;
        bus.mem_req    = 1'b0;
        bus.AdrSrc     = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.RegWrite   = 1'b0;
        bus.ResultSrc  = 1'b0;
        bus.A3Src      = 1'b0;
        bus.PCWrite    = 1'b0;
        bus.Branch     = 1'b0;
        bus.OldPCWrite = 1'b0;
        bus.MDRWrite   = 1'b0;
        bus.ALUSrcA    = 2'b00;
        bus.ALUSrcB    = 2'b00;
        bus.ImmSrc     = 2'b00;
        bus.PCSrc      = 2'b00;
        bus.halted     = 1'b0;
        bus.retire     = 1'b0;
        case (state_q)
            S_IF: begin
                if (bus.stall_req) begin
                    state_d = S_HALT;
                end else begin
                    bus.mem_req = 1'b1;
                    if (bus.mem_ready) begin
                        bus.IRWrite    = 1'b1;
                        bus.PCWrite    = 1'b1;
                        bus.OldPCWrite = 1'b1;
                        bus.ALUSrcB    = 2'b01;
                        state_d        = S_ID;
                    end else if (timeout) begin
                        bus_err_d = 1'b1;
                        state_d   = S_TRAP;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end
            end
            S_HALT: begin
                bus.halted = 1'b1;
                if (!bus.stall_req) state_d = S_IF;
            end
            S_ID: begin
                if      (bus.opcode == OP_LD)      state_d = S_LD_EX;
                else if (bus.opcode == OP_ST)      state_d = S_ST_EX;
                else if (bus.opcode == OP_JMP)     state_d = S_JUMP;
                else if (bus.opcode == OP_BR)      state_d = S_BRANCH;
                else if (bus.opcode == OP_C)       state_d = S_C_ALU;
                else if (bus.opcode[3:2] == 2'b11) state_d = S_IMM_EX;
                else begin
                    illegal_d = 1'b1;
                    state_d   = S_TRAP;
                end
            end
            S_BRANCH: begin
                bus.ALUSrcA = 2'b10;
                alu_fixed   = ALU_SUB;
                bus.PCSrc   = 2'b10;
                bus.Branch  = 1'b1;
                bus.retire  = 1'b1;
                state_d     = S_IF;
            end
            S_JUMP: begin
                bus.PCSrc   = 2'b01;
                bus.PCWrite = 1'b1;
                bus.retire  = 1'b1;
                state_d     = S_IF;
            end
            S_C_ALU: begin
                bus.ALUSrcA = 2'b10;
                aluop       = AOP_FUNC;
                state_d     = S_C_WB;
            end
            S_C_WB: begin
                bus.A3Src    = move_to;
                bus.RegWrite = ~no_op;
                bus.retire   = 1'b1;
                state_d      = S_IF;
            end
            S_ST_EX, S_LD_EX: begin
                bus.ALUSrcB = 2'b10;
                alu_fixed   = ALU_PASSB;
                state_d     = (state_q == S_ST_EX) ? S_ST_MEM : S_LD_MEM;
            end
            S_ST_MEM, S_LD_MEM: begin
                bus.mem_req = 1'b1;
                bus.AdrSrc  = 1'b1;
                if (bus.mem_ready) begin
                    bus.MemWrite = (state_q == S_ST_MEM);
                    bus.MDRWrite = (state_q == S_LD_MEM);
                    bus.retire   = (state_q == S_ST_MEM);
                    state_d      = (state_q == S_ST_MEM) ? S_IF : S_LD_WB;
                end else if (timeout) begin
                    bus_err_d = 1'b1;
                    state_d   = S_TRAP;
                end else begin
                    bus.MemWrite = (state_q == S_ST_MEM);
                    wait_d       = wait_q + WAIT_W'(1);
                end
            end
            S_LD_WB: begin
                bus.ResultSrc = 1'b1;
                bus.RegWrite  = 1'b1;
                bus.retire    = 1'b1;
                state_d       = S_IF;
            end
            S_IMM_EX: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUSrcB = 2'b10;
                // opcode[1:0] 00/01/10/11 lines up with add/sub/and/or
                alu_fixed   = {1'b0, bus.opcode[1:0]};
                state_d     = S_IMM_WB;
            end
            S_IMM_WB: begin
                bus.RegWrite = 1'b1;
                bus.retire   = 1'b1;
                state_d      = S_IF;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
    end

    // Retired-instruction count, wraps
    always_comb instret_d = instret_q + CNT_W'(bus.retire);

    // State, wait counter, instret and sticky trap flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IF;
            wait_q    <= '0;
            instret_q <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            instret_q <= instret_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign bus.ALUControl = alu_ctrl;
    assign bus.illegal_op = illegal_q;
    assign bus.bus_err    = bus_err_q;
    assign bus.instret    = instret_q;

endmodule
